multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle MIPS-subset datapath. Sequences the shared
//  ALU, memory port and PC/ALU-B/write-back select muxes across FETCH..WRITEBACK
//  steps per instruction. Handshakes with the unified memory via MemReady and
//  aborts hung accesses with a timeout.
// PARAMETERS
//  TIMEOUT  16  max cycles waiting for MemReady in a memory state (1..255); 0 = no timeout
// PORTS
//  Clk        in   1  clock, rising edge
//  Reset      in   1  asynchronous, active-high reset
//  Opcode     in   6  IR[31:26], valid from DECODE onward
//  Zero       in   1  ALU zero flag
//  MemReady   in   1  memory access complete this cycle
//  PCWrite    out  1  PC register load enable
//  PCSel      out  2  PC mux: 00 ALU result, 01 ALUOut (branch target), 10 jump target
//  IorD       out  1  memory address mux: 0 PC, 1 ALUOut
//  MemRead    out  1  memory read request
//  MemWrite   out  1  memory write request
//  IRWrite    out  1  instruction register load enable
//  RegDst     out  1  dest reg mux: 0 rt, 1 rd
//  MemToReg   out  1  write-back mux: 0 ALUOut, 1 MDR
//  RegWrite   out  1  register file write enable
//  ALUSrcA    out  1  ALU A mux: 0 PC, 1 rs
//  ALUSrcB    out  2  ALU B mux: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  ALUOp      out  2  00 add, 01 sub, 10 funct-decoded
//  IllegalOp  out  1  one-cycle pulse: unsupported opcode
//  MemError   out  1  one-cycle pulse: memory timeout
//  State      out  4  current state encoding (debug)
// BEHAVIOUR
//  - Reset asserted: state=START immediately; wait counter=0; every output 0.
//  - States/encoding: START=0 FETCH=1 DECODE=2 MEM_ADDR=3 MEM_RD=4 WB_MEM=5
//    MEM_WR=6 EXEC_R=7 WB_R=8 EXEC_I=9 WB_I=10 BRANCH=11 JUMP=12 ILLEGAL=13 TIMEOUT=14.
//  - Outputs are a decode of State; only listed signals are 1/non-zero in each state.
//    PCWrite/IRWrite/RegWrite/MemWrite never assert outside listed states.
//  - START: all 0 -> FETCH next cycle.
//  - FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSel=00;
//    IRWrite=PCWrite=MemReady (same-cycle); MemReady -> DECODE, else hold.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next by Opcode: 000000 EXEC_R,
//    100011/101011 MEM_ADDR, 001000 EXEC_I, 000100 BRANCH, 000010 JUMP, other ILLEGAL.
//  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM_RD (lw) / MEM_WR (sw).
//  - MEM_RD: MemRead, IorD=1; MemReady -> WB_MEM. WB_MEM: RegWrite, MemToReg=1, RegDst=0 -> FETCH.
//  - MEM_WR: MemWrite, IorD=1; MemReady -> FETCH.
//  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_R: RegWrite, RegDst=1 -> FETCH.
//  - EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> WB_I: RegWrite, RegDst=0 -> FETCH.
//  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSel=01, PCWrite=Zero -> FETCH.
//  - JUMP: PCSel=10, PCWrite -> FETCH.  ILLEGAL: IllegalOp -> FETCH (PC already +4).
//  - Wait counter (8b): cleared on entry to FETCH/MEM_RD/MEM_WR, +1 per cycle in those
//    states without MemReady. TIMEOUT>0 and count reaches TIMEOUT-1 with no MemReady
//    -> TIMEOUT state: MemError, all write enables 0 -> FETCH. MemReady on the
//    terminal cycle wins (normal transition, no error).
//  - MemReady outside FETCH/MEM_RD/MEM_WR is ignored.
//  - Reset mid-instruction: abort at once; no write enable asserts after Reset rises.
//  - Latency (MemReady tied 1): R/addi 4 cycles, lw 5, sw 4, beq 3, j 3.
// TESTING
//  - Reset, release, MemReady=1 -> State 0,1,...; all outputs 0 during Reset and START.
//  - Opcode=000000, MemReady=1 -> States 1,2,7,8,1; RegWrite=1,RegDst=1 only in WB_R.
//  - lw (100011), MemReady low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then
//    WB_MEM with MemToReg=1, RegWrite=1.
//  - beq (000100): Zero=0 -> PCWrite=0 in BRANCH; Zero=1 -> PCWrite=1, PCSel=01.
//  - TIMEOUT=4, sw with MemReady=0 -> 4 cycles in MEM_WR, TIMEOUT, MemError 1 cycle,
//    MemWrite=0 afterwards, back to FETCH; repeat with MemReady on 4th cycle -> no error.
//  - Opcode=111111 -> ILLEGAL, IllegalOp 1 cycle; Reset pulsed mid MEM_RD -> State=0
//    same cycle, no RegWrite.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS-subset datapath.
// Outputs decode the current state; memory waits are bounded by TIMEOUT.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic [1:0] PCSel,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       IllegalOp,
  output logic       MemError,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_START    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_WB_I     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13,
    S_TIMEOUT  = 4'd14
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [7:0] W_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_wait;
  logic [7:0] w_wait_inc;
  logic       w_tmo;

  assign w_wait_inc = (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;
  assign w_tmo = (TIMEOUT != 0) && (r_wait == W_LAST) && !MemReady;

  // Counter clears by default so every entry to a wait state starts at zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_START;
      r_wait  <= 8'd0;
    end else begin
      r_wait <= 8'd0;
      case (r_state)
        S_START: r_state <= S_FETCH;
        S_FETCH: begin
          if (MemReady)   r_state <= S_DECODE;
          else if (w_tmo) r_state <= S_TIMEOUT;
          else            r_wait  <= w_wait_inc;
        end
        S_DECODE: begin
          case (Opcode)
            OP_R:         r_state <= S_EXEC_R;
            OP_LW, OP_SW: r_state <= S_MEM_ADDR;
            OP_ADDI:      r_state <= S_EXEC_I;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_ILLEGAL;
          endcase
        end
        S_MEM_ADDR:
          r_state <= (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: begin
          if (MemReady)   r_state <= S_WB_MEM;
          else if (w_tmo) r_state <= S_TIMEOUT;
          else            r_wait  <= w_wait_inc;
        end
        S_MEM_WR: begin
          if (MemReady)   r_state <= S_FETCH;
          else if (w_tmo) r_state <= S_TIMEOUT;
          else            r_wait  <= w_wait_inc;
        end
        S_EXEC_R:  r_state <= S_WB_R;
        S_EXEC_I:  r_state <= S_WB_I;
        S_WB_MEM,
        S_WB_R,
        S_WB_I,
        S_BRANCH,
        S_JUMP,
        S_ILLEGAL,
        S_TIMEOUT: r_state <= S_FETCH;
        default:   r_state <= S_START;
      endcase
    end
  end

  always_comb begin
    PCWrite   = 1'b0;
    PCSel     = 2'b00;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemToReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    IllegalOp = 1'b0;
    MemError  = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEM_ADDR,
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_WB_I: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSel   = 2'b01;
        PCWrite = Zero;
      end
      S_JUMP: begin
        PCSel   = 2'b10;
        PCWrite = 1'b1;
      end
      S_ILLEGAL: IllegalOp = 1'b1;
      S_TIMEOUT: MemError  = 1'b1;
      default: ;
    endcase
  end

  assign State = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with TIMEOUT=4.
// Each vector gives inputs for a cycle and the expected state and outputs.
module tb_multicycle_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] Opcode = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemToReg, RegWrite, ALUSrcA;
  logic       IllegalOp, MemError;
  logic [1:0] PCSel, ALUSrcB, ALUOp;
  logic [3:0] State;
  logic [16:0] w_outs;

  int n_chk = 0;
  int n_fail = 0;

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCSel(PCSel),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .IllegalOp(IllegalOp), .MemError(MemError),
    .State(State)
  );

  always #5 Clk = ~Clk;

  // PCWrite PCSel IorD MemRead MemWrite IRWrite RegDst MemToReg
  // RegWrite ALUSrcA ALUSrcB ALUOp IllegalOp MemError
  assign w_outs = {PCWrite, PCSel, IorD, MemRead, MemWrite, IRWrite,
                   RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB,
                   ALUOp, IllegalOp, MemError};

  localparam logic [16:0] O_ZERO = 17'd0;
  localparam logic [16:0] O_FRDY = 17'b1_00_0_1_0_1_0_0_0_0_01_00_0_0;
  localparam logic [16:0] O_FWT  = 17'b0_00_0_1_0_0_0_0_0_0_01_00_0_0;
  localparam logic [16:0] O_DEC  = 17'b0_00_0_0_0_0_0_0_0_0_11_00_0_0;
  localparam logic [16:0] O_EXR  = 17'b0_00_0_0_0_0_0_0_0_1_00_10_0_0;
  localparam logic [16:0] O_WBR  = 17'b0_00_0_0_0_0_1_0_1_0_00_00_0_0;
  localparam logic [16:0] O_ADR  = 17'b0_00_0_0_0_0_0_0_0_1_10_00_0_0;
  localparam logic [16:0] O_MRD  = 17'b0_00_1_1_0_0_0_0_0_0_00_00_0_0;
  localparam logic [16:0] O_WBM  = 17'b0_00_0_0_0_0_0_1_1_0_00_00_0_0;
  localparam logic [16:0] O_MWR  = 17'b0_00_1_0_1_0_0_0_0_0_00_00_0_0;
  localparam logic [16:0] O_WBI  = 17'b0_00_0_0_0_0_0_0_1_0_00_00_0_0;
  localparam logic [16:0] O_BR0  = 17'b0_01_0_0_0_0_0_0_0_1_00_01_0_0;
  localparam logic [16:0] O_BR1  = 17'b1_01_0_0_0_0_0_0_0_1_00_01_0_0;
  localparam logic [16:0] O_JMP  = 17'b1_10_0_0_0_0_0_0_0_0_00_00_0_0;
  localparam logic [16:0] O_ILL  = 17'b0_00_0_0_0_0_0_0_0_0_00_00_1_0;
  localparam logic [16:0] O_TMO  = 17'b0_00_0_0_0_0_0_0_0_0_00_00_0_1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic z,
                     input logic [5:0] op, input logic [3:0] st,
                     input logic [16:0] ov);
    MemReady = rdy;
    Zero = z;
    Opcode = op;
    #1;
    check({tag, ".state"}, int'(State), int'(st));
    check({tag, ".outs"}, int'(w_outs), int'(ov));
    @(posedge Clk);
    #2;
  endtask

  task automatic fetch_dec(input string tag, input logic [5:0] op);
    cyc({tag, ".fetch"}, 1'b1, 1'b0, op, 4'd1, O_FRDY);
    cyc({tag, ".decode"}, 1'b1, 1'b0, op, 4'd2, O_DEC);
  endtask

  initial begin
    #3;
    check("rst.state", int'(State), 0);
    check("rst.outs", int'(w_outs), int'(O_ZERO));
    repeat (2) @(posedge Clk);
    #2;
    check("rst.hold", int'(State), 0);
    Reset = 1'b0;
    cyc("start", 1'b1, 1'b0, 6'd0, 4'd0, O_ZERO);

    fetch_dec("rtype", 6'b000000);
    cyc("rtype.exec", 1'b0, 1'b0, 6'b000000, 4'd7, O_EXR);
    cyc("rtype.wb", 1'b0, 1'b0, 6'b000000, 4'd8, O_WBR);

    fetch_dec("addi", 6'b001000);
    cyc("addi.exec", 1'b1, 1'b0, 6'b001000, 4'd9, O_ADR);
    cyc("addi.wb", 1'b1, 1'b0, 6'b001000, 4'd10, O_WBI);

    fetch_dec("lw", 6'b100011);
    cyc("lw.addr", 1'b1, 1'b0, 6'b100011, 4'd3, O_ADR);
    for (int i = 0; i < 3; i++)
      cyc("lw.wait", 1'b0, 1'b0, 6'b100011, 4'd4, O_MRD);
    cyc("lw.rdy", 1'b1, 1'b0, 6'b100011, 4'd4, O_MRD);
    cyc("lw.wb", 1'b0, 1'b0, 6'b100011, 4'd5, O_WBM);

    fetch_dec("beq0", 6'b000100);
    cyc("beq0.br", 1'b1, 1'b0, 6'b000100, 4'd11, O_BR0);
    fetch_dec("beq1", 6'b000100);
    cyc("beq1.br", 1'b1, 1'b1, 6'b000100, 4'd11, O_BR1);

    fetch_dec("j", 6'b000010);
    cyc("j.jump", 1'b0, 1'b0, 6'b000010, 4'd12, O_JMP);

    fetch_dec("swto", 6'b101011);
    cyc("swto.addr", 1'b0, 1'b0, 6'b101011, 4'd3, O_ADR);
    for (int i = 0; i < 4; i++)
      cyc("swto.wait", 1'b0, 1'b0, 6'b101011, 4'd6, O_MWR);
    cyc("swto.tmo", 1'b0, 1'b0, 6'b101011, 4'd14, O_TMO);
    cyc("swto.back", 1'b0, 1'b0, 6'b101011, 4'd1, O_FWT);
    MemReady = 1'b1;
    @(posedge Clk);
    #2;

    cyc("swok.decode", 1'b0, 1'b0, 6'b101011, 4'd2, O_DEC);
    cyc("swok.addr", 1'b0, 1'b0, 6'b101011, 4'd3, O_ADR);
    for (int i = 0; i < 3; i++)
      cyc("swok.wait", 1'b0, 1'b0, 6'b101011, 4'd6, O_MWR);
    cyc("swok.last", 1'b1, 1'b0, 6'b101011, 4'd6, O_MWR);
    for (int i = 0; i < 4; i++)
      cyc("fto.wait", 1'b0, 1'b0, 6'b000000, 4'd1, O_FWT);
    cyc("fto.tmo", 1'b1, 1'b0, 6'b000000, 4'd14, O_TMO);

    fetch_dec("ill", 6'b111111);
    cyc("ill.pulse", 1'b0, 1'b0, 6'b111111, 4'd13, O_ILL);
    cyc("ill.back", 1'b0, 1'b0, 6'b111111, 4'd1, O_FWT);
    MemReady = 1'b1;
    @(posedge Clk);
    #2;

    cyc("rmid.decode", 1'b1, 1'b0, 6'b100011, 4'd2, O_DEC);
    cyc("rmid.addr", 1'b1, 1'b0, 6'b100011, 4'd3, O_ADR);
    cyc("rmid.rd", 1'b0, 1'b0, 6'b100011, 4'd4, O_MRD);
    MemReady = 1'b1;
    Reset = 1'b1;
    #1;
    check("rmid.state", int'(State), 0);
    check("rmid.outs", int'(w_outs), int'(O_ZERO));
    @(posedge Clk);
    #2;
    check("rmid.hold", int'(State), 0);
    check("rmid.regwr", int'(RegWrite), 0);
    Reset = 1'b0;
    cyc("rmid.start", 1'b1, 1'b0, 6'd0, 4'd0, O_ZERO);
    cyc("rmid.fetch", 1'b1, 1'b0, 6'd0, 4'd1, O_FRDY);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
